// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core package for the 5-stage pipeline.
// Holds the hazard-controller state encoding, the default mul/div latency
// and the operand-forwarding source encodings used by the bypass muxes.
package pipeline_hazard_ctrl_pkg;

  // Hazard controller states
  typedef enum logic {
    HC_RUN     = 1'b0,
    HC_MD_BUSY = 1'b1
  } hc_state_e;

  // Total cycles a mul/div instruction occupies EX
  localparam int HC_MD_CYCLES_DEFAULT = 32;

  // Operand forwarding sources for the EX-stage bypass muxes
  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,  // register file value from ID/EX
    FWD_EX_MEM = 2'b01,  // result in EX/MEM
    FWD_MEM_WB = 2'b10   // result in MEM/WB
  } fwd_src_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// hc_perf_counter: wrapping event counter with enable.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears the count
//   en    - count this cycle
//   count - current count, wraps at 2^W
module hc_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, wrapping naturally at the register width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (en) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the IF/ID/EX/MEM/WB core.
// Resolves hazards that forwarding cannot: load-use, taken-branch redirect,
// the multi-cycle mul/div unit holding EX, and data-memory wait states.
// Ports:
//   clk_i, rst_ni                 - clock, asynchronous active-low reset
//   id_sel_rs1_i/id_sel_rs2_i     - sources of the instruction in ID
//   ex_sel_rd_i, ex_is_load_i     - destination / load flag of EX instruction
//   ex_is_muldiv_i                - EX holds a mul/div
//   ex_branch_taken_i             - EX resolved a taken branch/jump
//   dmem_req_i, dmem_ready_i      - MEM-stage data memory handshake
//   stall_*_o                     - hold PC / stage output registers
//   flush_id_o                    - clear IF/ID
//   bubble_*_o                    - insert NOP into ID/EX, EX/MEM, MEM/WB
//   muldiv_start_o/muldiv_done_o  - mul/div unit start pulse / result valid
//   md_busy_o                     - controller is in MD_BUSY
//   stall_cycles_o                - count of cycles with stall_if_o high
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = HC_MD_CYCLES_DEFAULT,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_sel_rs1_i,
  input  logic [4:0]       id_sel_rs2_i,
  input  logic [4:0]       ex_sel_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_is_muldiv_i,
  input  logic             ex_branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_id_o,
  output logic             bubble_ex_o,
  output logic             bubble_mem_o,
  output logic             bubble_wb_o,
  output logic             muldiv_start_o,
  output logic             muldiv_done_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int CW = $clog2(MD_CYCLES);
  // Busy cycles that still stall after the start cycle; the final one is done
  localparam logic [CW-1:0] MD_INIT = CW'(MD_CYCLES - 2);

  hc_state_e       state_q, state_d;
  logic [CW-1:0]   md_cnt_q, md_cnt_d;
  logic            mem_wait;
  logic            load_use;

  assign mem_wait = dmem_req_i && !dmem_ready_i;
  assign load_use = ex_is_load_i && (ex_sel_rd_i != 5'd0) &&
                    ((ex_sel_rd_i == id_sel_rs1_i) || (ex_sel_rd_i == id_sel_rs2_i));
  assign md_busy_o = (state_q == HC_MD_BUSY);

  // State and mul/div countdown registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= HC_RUN;
      md_cnt_q <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state and pipeline control decode
  always_comb begin
    state_d        = state_q;
    md_cnt_d       = md_cnt_q;
    stall_if_o     = 1'b0;
    stall_id_o     = 1'b0;
    stall_ex_o     = 1'b0;
    stall_mem_o    = 1'b0;
    flush_id_o     = 1'b0;
    bubble_ex_o    = 1'b0;
    bubble_mem_o   = 1'b0;
    bubble_wb_o    = 1'b0;
    muldiv_start_o = 1'b0;
    muldiv_done_o  = 1'b0;
    if (mem_wait) begin
      // Freeze the whole pipe; state and countdown hold
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      bubble_wb_o = 1'b1;
    end else begin
      case (state_q)
        HC_RUN: begin
          if (ex_is_muldiv_i) begin
            muldiv_start_o = 1'b1;
            stall_if_o     = 1'b1;
            stall_id_o     = 1'b1;
            stall_ex_o     = 1'b1;
            bubble_mem_o   = 1'b1;
            state_d        = HC_MD_BUSY;
            md_cnt_d       = MD_INIT;
          end else if (ex_branch_taken_i) begin
            // Branch wins over a (nonsensical) simultaneous load-use
            flush_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
          end else if (load_use) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
          end else begin
            state_d = HC_RUN;
          end
        end
        HC_MD_BUSY: begin
          if (md_cnt_q != {CW{1'b0}}) begin
            stall_if_o   = 1'b1;
            stall_id_o   = 1'b1;
            stall_ex_o   = 1'b1;
            bubble_mem_o = 1'b1;
            md_cnt_d     = md_cnt_q - CW'(1);
          end else begin
            // The mul/div leaves EX this cycle, so it cannot restart
            muldiv_done_o = 1'b1;
            state_d       = HC_RUN;
          end
        end
        default: begin
          state_d  = HC_RUN;
          md_cnt_d = {CW{1'b0}};
        end
      endcase
    end
  end

  hc_perf_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (stall_if_o),
    .count (stall_cycles_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MD_CYCLES=4, CNT_W=4 so the
// stall counter wrap is reachable). The driver pushes the hand-computed
// control vector for each cycle; the monitor pops and compares on negedge.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  // Control vector bit values, packed as in the monitor concatenation
  localparam logic [10:0] SIF   = 11'h400;
  localparam logic [10:0] SID   = 11'h200;
  localparam logic [10:0] SEX   = 11'h100;
  localparam logic [10:0] SMEM  = 11'h080;
  localparam logic [10:0] FLU   = 11'h040;
  localparam logic [10:0] BEX   = 11'h020;
  localparam logic [10:0] BMEM  = 11'h010;
  localparam logic [10:0] BWB   = 11'h008;
  localparam logic [10:0] START = 11'h004;
  localparam logic [10:0] DONE  = 11'h002;
  localparam logic [10:0] BUSY  = 11'h001;

  localparam logic [10:0] IDLE = 11'h000;
  localparam logic [10:0] LU   = SIF | SID | BEX;
  localparam logic [10:0] BR   = FLU | BEX;
  localparam logic [10:0] MDS  = START | SIF | SID | SEX | BMEM;
  localparam logic [10:0] MDB  = BUSY | SIF | SID | SEX | BMEM;
  localparam logic [10:0] MDD  = BUSY | DONE;
  localparam logic [10:0] MW   = SIF | SID | SEX | SMEM | BWB;

  typedef struct {
    logic [10:0]   ctl;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [4:0]    rs1, rs2, rd;
  logic          ld, md, br, req, rdy;
  logic          stall_if, stall_id, stall_ex, stall_mem, flush_id;
  logic          bubble_ex, bubble_mem, bubble_wb, md_start, md_done, md_busy;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MD_CYCLES (4),
    .CNT_W     (CW)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .id_sel_rs1_i      (rs1),
    .id_sel_rs2_i      (rs2),
    .ex_sel_rd_i       (rd),
    .ex_is_load_i      (ld),
    .ex_is_muldiv_i    (md),
    .ex_branch_taken_i (br),
    .dmem_req_i        (req),
    .dmem_ready_i      (rdy),
    .stall_if_o        (stall_if),
    .stall_id_o        (stall_id),
    .stall_ex_o        (stall_ex),
    .stall_mem_o       (stall_mem),
    .flush_id_o        (flush_id),
    .bubble_ex_o       (bubble_ex),
    .bubble_mem_o      (bubble_mem),
    .bubble_wb_o       (bubble_wb),
    .muldiv_start_o    (md_start),
    .muldiv_done_o     (md_done),
    .md_busy_o         (md_busy),
    .stall_cycles_o    (stall_cycles)
  );

  // Monitor: outputs are valid every cycle; compare against the queued vector
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e   = exp_q.pop_front();
      act = {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
             bubble_mem, bubble_wb, md_start, md_done, md_busy};
      total = total + 1;
      if (act !== e.ctl || stall_cycles !== e.cnt) begin
        bad = bad + 1;
        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 e.name, act, stall_cycles, e.ctl, e.cnt);
      end
    end
  end

  task automatic push(input string name, input logic [10:0] ctl, input logic [CW-1:0] cnt);
    exp_t e;
    e.ctl  = ctl;
    e.cnt  = cnt;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic l, input logic m, input logic b,
                       input logic q, input logic y);
    rs1 = r1; rs2 = r2; rd = d; ld = l; md = m; br = b; req = q; rdy = y;
  endtask

  // One cycle: inputs applied just after posedge, expectation queued
  task automatic step(input string name,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                      input logic l, input logic m, input logic b,
                      input logic q, input logic y,
                      input logic [10:0] ctl, input logic [CW-1:0] cnt);
    @(posedge clk);
    #1;
    drive(r1, r2, d, l, m, b, q, y);
    push(name, ctl, cnt);
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    push("reset_idle", IDLE, 4'd0);
    @(negedge clk);
    #1;
    rst_ni = 1'b1;

    //    name            rs1    rs2    rd    ld    md    br    req   rdy   ctl        cnt
    step("idle0",        5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd0);
    step("lu_rs1",       5'd5,  5'd0,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU,        4'd0);
    step("lu_after",     5'd5,  5'd0,  5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd1);
    step("lu_rd0",       5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd1);
    step("lu_rs2",       5'd3,  5'd7,  5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU,        4'd1);
    step("ld_nomatch",   5'd3,  5'd4,  5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd2);
    step("branch",       5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR,        4'd2);
    step("branch_vs_lu", 5'd5,  5'd0,  5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, BR,        4'd2);
    step("idle1",        5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd2);
    // Mul/div, MD_CYCLES=4: start, busy, busy, done
    step("md_start",     5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDS,       4'd2);
    step("md_busy1",     5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDB,       4'd3);
    step("md_busy2_br",  5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, MDB,       4'd4);
    step("md_done",      5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDD,       4'd5);
    // Back-to-back mul/div: fresh start right after done
    step("md2_start",    5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDS,       4'd5);
    step("md2_busy1",    5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDB,       4'd6);
    step("md2_busy2",    5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDB,       4'd7);
    step("md2_done",     5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MDD,       4'd8);
    step("idle2",        5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd8);
    // Memory wait on the cycle the mul/div arrives, then again while busy
    step("mw_md0",       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, MW,        4'd8);
    step("mw_md1",       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, MW,        4'd9);
    step("mw_md2",       5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, MW,        4'd10);
    step("mw_start",     5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDS,       4'd11);
    step("mw_busy1",     5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDB,       4'd12);
    step("mw_in_busy",   5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, MW | BUSY, 4'd13);
    step("mw_busy2",     5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDB,       4'd14);
    step("mw_done",      5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MDD,       4'd15);
    step("idle3",        5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd15);
    step("mem_ready",    5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, IDLE,      4'd15);
    // Stall counter wraps from 15 to 0
    step("lu_wrap",      5'd9,  5'd0,  5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU,        4'd15);
    step("after_wrap",   5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd0);
    // Reset while busy abandons the operation
    step("rb_start",     5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDS,       4'd0);
    step("rb_busy",      5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MDB,       4'd1);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("rst_in_busy", IDLE, 4'd0);
    @(negedge clk);
    #1;
    rst_ni = 1'b1;
    step("post_rst0",    5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd0);
    step("post_rst1",    5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,      4'd0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() != 0) begin
        @(negedge clk);
      end
    end
    #1;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage core (IF/ID/EX/MEM/WB), sitting beside the operand-forwarding logic. It resolves hazards that forwarding cannot cover: load-use, taken-branch redirect, the multi-cycle mul/div unit occupying EX, and data-memory wait states. It drives per-stage stall and bubble controls for the pipeline registers and keeps a stall-cycle performance counter.

## Interface
- MD_CYCLES, 32, total cycles a mul/div instruction occupies EX (must be ≥ 2)
- CNT_W, 32, width of the stall-cycle counter
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- id_sel_rs1_i / id_sel_rs2_i  in  5  source registers of the instruction in ID (x0 = unused)
- ex_sel_rd_i  in  5  destination register of the instruction in EX
- ex_is_load_i  in  1  EX holds a load
- ex_is_muldiv_i  in  1  EX holds a mul/div
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump
- dmem_req_i  in  1  MEM stage is accessing data memory
- dmem_ready_i  in  1  data memory completes the access this cycle
- stall_if_o / stall_id_o / stall_ex_o / stall_mem_o  out  1  hold the PC or the corresponding stage's output register
- flush_id_o  out  1  clear the IF/ID register
- bubble_ex_o / bubble_mem_o / bubble_wb_o  out  1  load a NOP into ID/EX, EX/MEM or MEM/WB
- muldiv_start_o  out  1  one-cycle start pulse to the mul/div unit
- muldiv_done_o  out  1  mul/div result valid; EX advances this cycle
- md_busy_o  out  1  state is MD_BUSY
- stall_cycles_o  out  CNT_W  count of cycles with stall_if_o high; wraps

## Operation
- State machine has two states, RUN and MD_BUSY, plus a down-counter md_cnt of width $clog2(MD_CYCLES). All other controls are combinational from the state and the inputs.
- mem_wait = dmem_req_i && !dmem_ready_i. This condition has top priority in any state:
  - all four stall outputs are high, bubble_wb_o is high, and every other control is 0;
  - the state and md_cnt hold.
- load_use = ex_is_load_i && ex_sel_rd_i != 0 && (ex_sel_rd_i == id_sel_rs1_i || ex_sel_rd_i == id_sel_rs2_i).
- RUN, without mem_wait, uses this priority order:
  1. ex_is_muldiv_i: muldiv_start_o=1, stall_if/id/ex=1, bubble_mem_o=1. Go to MD_BUSY with md_cnt=MD_CYCLES-2.
  2. ex_branch_taken_i: flush_id_o=1, bubble_ex_o=1, no stalls.
  3. load_use: stall_if/id=1, bubble_ex_o=1. The load moves on to MEM, so the stall lasts exactly one cycle.
  4. Otherwise all outputs are 0.
- MD_BUSY, without mem_wait:
  - If md_cnt != 0: stall_if/id/ex=1, bubble_mem_o=1, and md_cnt decrements. ex_is_muldiv_i and ex_branch_taken_i are ignored.
  - If md_cnt == 0: muldiv_done_o=1, no stall, and the state returns to RUN. The same mul/div instruction leaves EX, so it never restarts.
- Back-to-back mul/div instructions each get a fresh start in the RUN cycle after done.
- stall_cycles_o increments on every cycle in which stall_if_o=1, wrapping at 2^CNT_W.
- A load and a taken branch cannot both be in EX. If the inputs present both, the branch takes priority.

## Timing
- Reset (asynchronous, with rst_ni low) sets the state to RUN, md_cnt=0 and stall_cycles_o=0.
  - With idle inputs during reset, every control output is 0.
  - Reset taken in MD_BUSY abandons the operation; no muldiv_done_o is generated.
- Latency:
  - Load-use costs 1 bubble.
  - A taken branch costs 2 killed slots in the same cycle.
  - A mul/div holds EX for exactly MD_CYCLES cycles: the start cycle, then MD_CYCLES-1 cycles in MD_BUSY, the last of which asserts done.
- mem_wait extends any of the above one-for-one: a frozen cycle consumes no md_cnt decrement and issues no start.
- muldiv_start_o is a single pulse. It is never asserted during mem_wait or in MD_BUSY.

## Structure
- The shared core package holds:
  - typedef enum logic {HC_RUN, HC_MD_BUSY} hc_state_e;
  - the default MD_CYCLES constant;
  - the existing forwarding-source encodings.
- Optional sub-module: hc_perf_counter, containing the wrapping stall counter with enable. Everything else stays flat in pipeline_hazard_ctrl.

## Test plan
- Load-use: ex_is_load_i=1, ex_sel_rd_i=5, id_sel_rs1_i=5 → exactly 1 cycle of stall_if/id=1 and bubble_ex_o=1; stall_cycles_o goes 0→1. Repeat with rd=0 → no stall.
- Taken branch: ex_branch_taken_i=1 for one cycle → flush_id_o=1 and bubble_ex_o=1 in that cycle, no stalls, counter unchanged.
- Mul/div with MD_CYCLES=4:
  - start pulse in cycle 0;
  - stall_ex_o=1 for cycles 0-2, md_busy_o=1 for cycles 1-3;
  - muldiv_done_o=1 in cycle 3 only, then state RUN;
  - stall_cycles_o increases by 3.
- Memory wait during mul/div: dmem_ready_i=0 with dmem_req_i=1 for 3 cycles in the same cycle ex_is_muldiv_i rises → all stalls plus bubble_wb_o for 3 cycles and no start pulse; start occurs in cycle 3 and done in cycle 6.
- Back-to-back mul/div (MD_CYCLES=2) → two start pulses 2 cycles apart, two done pulses, and no double start on the done cycle.
- Reset asserted in MD_BUSY with md_cnt=10 → state RUN, all outputs 0, counter 0. After release, there is no spurious muldiv_done_o.
